// File: rtl/mcp3008_responder.sv
`default_nettype none
// ============================================================================
// Module   : mcp3008_responder
// Function : SPI (mode 0,0) responder modelling an MCP3008 8-channel 10-bit
//            ADC. SCK/CS/MOSI are oversampled in the clk domain. The start
//            bit and the 4-bit channel command are decoded, and the selected
//            (single-ended or clamped differential) sample is shifted out on
//            MISO: MSB-first, then LSB-first, then zeros.
// Revision : 1.0 - initial release
// ============================================================================
module mcp3008_responder #(
    // Synchronizer depth on the SPI pins; must be 2 or more
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [79:0] ch_data,
    input  logic        spi_sck,
    input  logic        spi_cs,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    output logic        cmd_valid,
    output logic        cmd_sgl,
    output logic [2:0]  cmd_sel
);

    localparam int         LAST    = SYNC_STAGES - 1;
    localparam logic [4:0] IDX_MAX = 5'd31;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_START = 3'd1,
        S_CMD        = 3'd2,
        S_SAMPLE     = 3'd3,
        S_MSB        = 3'd4,
        S_LSB        = 3'd5,
        S_ZERO       = 3'd6
    } state_t;

    // ------------------------------------------------------------------
    // Pin synchronizers
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sck_sync_q,  sck_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sck_dly_q,   sck_dly_d;

    // Shift each pin one stage deeper; sck_dly keeps the previous SCK level
    always_comb begin
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0],  spi_sck};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0],   spi_cs};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        sck_dly_d   = sck_sync_q[LAST];
    end

    // Synchronizers are not reset so that a CS already low at reset release
    // cannot masquerade as the start of a fresh frame
    always_ff @(posedge clk) begin
        sck_sync_q  <= sck_sync_d;
        cs_sync_q   <= cs_sync_d;
        mosi_sync_q <= mosi_sync_d;
        sck_dly_q   <= sck_dly_d;
    end

    logic sck_s;
    logic cs_s;
    logic mosi_s;
    logic sck_rise;
    logic sck_fall;

    assign sck_s    = sck_sync_q[LAST];
    assign cs_s     = cs_sync_q[LAST];
    assign mosi_s   = mosi_sync_q[LAST];
    assign sck_rise = sck_s & ~sck_dly_q;
    assign sck_fall = ~sck_s & sck_dly_q;

    // ------------------------------------------------------------------
    // Channel unpacking and conversion model
    // ------------------------------------------------------------------
    logic [9:0] ch [8];

    for (genvar gi = 0; gi < 8; gi++) begin : g_ch
        assign ch[gi] = ch_data[10*gi +: 10];
    end

    logic [2:0]  state_cmd_sr;
    logic [3:0]  cmd_word;
    logic [9:0]  in_pos;
    logic [9:0]  in_neg;
    logic [10:0] diff;
    logic [9:0]  conv;

    // The command completes when D0 arrives; the first three bits are
    // already in the shift register
    assign cmd_word = {state_cmd_sr, mosi_s};

    // IN+ is the selected channel; IN- is its pair partner (LSB flipped)
    always_comb begin
        in_pos = ch[cmd_word[2:0]];
        in_neg = ch[{cmd_word[2:1], ~cmd_word[0]}];
        diff   = {1'b0, in_pos} - {1'b0, in_neg};
        conv   = in_pos;
        if (!cmd_word[3]) begin
            conv = diff[10] ? 10'h000 : diff[9:0];
        end
    end

    // ------------------------------------------------------------------
    // Frame state machine
    // ------------------------------------------------------------------
    state_t     state_q,   state_d;
    logic [4:0] clk_idx_q, clk_idx_d;
    logic [2:0] cmd_sr_q,  cmd_sr_d;
    logic [9:0] hold_q,    hold_d;
    logic       miso_q,    miso_d;
    logic       oe_q,      oe_d;
    logic       valid_q,   valid_d;
    logic       sgl_q,     sgl_d;
    logic [2:0] sel_q,     sel_d;
    logic       armed_q,   armed_d;

    logic [4:0] clk_idx_inc;
    logic [3:0] msb_bit;
    logic [3:0] lsb_bit;

    assign state_cmd_sr = cmd_sr_q;
    assign clk_idx_inc  = (clk_idx_q == IDX_MAX) ? clk_idx_q : clk_idx_q + 5'd1;
    // Falls after rises 6..15 drive B9..B0; falls after 16..24 drive B1..B9
    assign msb_bit      = 4'd15 - clk_idx_q[3:0];
    assign lsb_bit      = clk_idx_q[3:0] - 4'd15;

    // Next-state and output logic; CS high overrides any SCK activity
    always_comb begin
        state_d   = state_q;
        clk_idx_d = clk_idx_q;
        cmd_sr_d  = cmd_sr_q;
        hold_d    = hold_q;
        miso_d    = miso_q;
        oe_d      = oe_q;
        valid_d   = 1'b0;
        sgl_d     = sgl_q;
        sel_d     = sel_q;
        armed_d   = armed_q;

        if (cs_s) begin
            state_d = S_IDLE;
            miso_d  = 1'b0;
            oe_d    = 1'b0;
            armed_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Only a CS low that follows an observed CS high opens a frame
                    if (armed_q) begin
                        armed_d = 1'b0;
                        state_d = S_WAIT_START;
                    end
                end
                S_WAIT_START: begin
                    if (sck_rise && mosi_s) begin
                        clk_idx_d = 5'd0;
                        state_d   = S_CMD;
                    end
                end
                S_CMD: begin
                    if (sck_rise) begin
                        clk_idx_d = clk_idx_inc;
                        cmd_sr_d  = {cmd_sr_q[1:0], mosi_s};
                        if (clk_idx_q == 5'd3) begin
                            sgl_d   = cmd_word[3];
                            sel_d   = cmd_word[2:0];
                            valid_d = 1'b1;
                            hold_d  = conv;
                            state_d = S_SAMPLE;
                        end
                    end
                end
                S_SAMPLE: begin
                    if (sck_rise) begin
                        clk_idx_d = clk_idx_inc;
                    end
                    if (sck_fall && (clk_idx_q == 5'd5)) begin
                        miso_d  = 1'b0;
                        oe_d    = 1'b1;
                        state_d = S_MSB;
                    end
                end
                S_MSB: begin
                    if (sck_rise) begin
                        clk_idx_d = clk_idx_inc;
                    end
                    if (sck_fall) begin
                        miso_d = hold_q[msb_bit];
                        if (clk_idx_q == 5'd15) begin
                            state_d = S_LSB;
                        end
                    end
                end
                S_LSB: begin
                    if (sck_rise) begin
                        clk_idx_d = clk_idx_inc;
                    end
                    if (sck_fall) begin
                        miso_d = hold_q[lsb_bit];
                        if (clk_idx_q == 5'd24) begin
                            state_d = S_ZERO;
                        end
                    end
                end
                S_ZERO: begin
                    if (sck_rise) begin
                        clk_idx_d = clk_idx_inc;
                    end
                    if (sck_fall) begin
                        miso_d = 1'b0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    miso_d  = 1'b0;
                    oe_d    = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            clk_idx_q <= 5'd0;
            cmd_sr_q  <= 3'd0;
            hold_q    <= 10'd0;
            miso_q    <= 1'b0;
            oe_q      <= 1'b0;
            valid_q   <= 1'b0;
            sgl_q     <= 1'b0;
            sel_q     <= 3'd0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_idx_q <= clk_idx_d;
            cmd_sr_q  <= cmd_sr_d;
            hold_q    <= hold_d;
            miso_q    <= miso_d;
            oe_q      <= oe_d;
            valid_q   <= valid_d;
            sgl_q     <= sgl_d;
            sel_q     <= sel_d;
            armed_q   <= armed_d;
        end
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = oe_q;
    assign cmd_valid   = valid_q;
    assign cmd_sgl     = sgl_q;
    assign cmd_sel     = sel_q;

endmodule
`default_nettype wire
